uart_tx_buffered: RTL and testbench

//  Responder side of the core's transmit interface: accepts the one-cycle tx_ready strobe plus sdata byte,

---
 rtl/uart_tx_buffered_pkg.sv | 18 +
 rtl/uart_tx_buffered_if.sv | 11 +
 rtl/uart_tx_buffered_sync_fifo.sv | 47 ++++
 rtl/uart_tx_buffered.sv | 149 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// rtl/uart_tx_buffered_pkg.sv - shared types and constants for the buffered UART transmitter
// Purpose: FSM state encoding, default baud divisor and frame geometry used by the top and bench.
// Ports: none (package).
package uart_tx_buffered_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // 100 MHz / 115200 baud
    localparam int DEFAULT_CLK_PER_BIT = 868;
    localparam int DATA_BITS           = 8;
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - core-to-transmitter byte strobe interface
// Purpose: groups the one-cycle push strobe and its data byte.
// Ports: tx_ready (push strobe), sdata (byte sampled with the strobe).
//        master = core side (drives), slave = transmitter side (receives).
interface uart_tx_buffered_if;
    logic       tx_ready;
    logic [7:0] sdata;

    modport master (output tx_ready, output sdata);
    modport slave  (input  tx_ready, input  sdata);
endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// rtl/uart_tx_buffered_sync_fifo.sv - synchronous FIFO queueing bytes ahead of the serialiser
// Purpose: power-of-two deep FIFO, head word visible combinationally on dout.
// Ports: clk, rstn (sync, active-low), push/din write, pop advances head,
//        dout head word, count occupancy, full, empty.
// The caller must not push when full without a simultaneous pop, nor pop when empty.
module uart_tx_buffered_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Low AW bits address the array and wrap mod DEPTH; the extra top bit
    // lets count = wr_ptr - rd_ptr tell full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter, LSB first
// Purpose: absorbs byte strobes from the core into a FIFO and serialises them on txd.
// Ports: clk, rstn (sync, active-low), tx (slave: tx_ready strobe + sdata),
//        txd serial line (idle high), busy, fifo_count (bytes queued, excluding
//        the one being shifted), overflow (sticky: strobe dropped while full).
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    uart_tx_buffered_if.slave            tx,
    output logic                         txd,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);
    localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_PER_BIT - 1);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             txd_n;
    logic             pop;
    logic             bit_end;

    // The strobe is captured first and written into the FIFO one edge later,
    // so a byte strobed at edge t into an idle block starts its frame at t+2.
    logic             push_q;
    logic [7:0]       data_q;
    logic             fifo_push;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    // A write into a full FIFO is still accepted when the head leaves that same edge.
    assign fifo_push = push_q & (~fifo_full | pop);

    uart_tx_buffered_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .din   (data_q),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end = (bit_cnt == LAST_CNT);
    assign busy    = (state != ST_IDLE) | (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            push_q   <= 1'b0;
            data_q   <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            txd     <= txd_n;
            push_q  <= tx.tx_ready;
            data_q  <= tx.sdata;
            if (push_q && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        txd_n     = txd;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_n = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_n   = fifo_dout;
                    txd_n     = 1'b0;
                    bit_cnt_n = '0;
                    state_n   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    txd_n     = shift[0];
                    bit_idx_n = '0;
                    bit_cnt_n = '0;
                    state_n   = ST_DATA;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    if (bit_idx == LAST_BIT_IDX) begin
                        txd_n   = 1'b1;
                        state_n = ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = shift >> 1;
                        txd_n     = shift[1];
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        txd_n   = 1'b0;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic busy39;

    uart_tx_buffered_if tx();

    uart_tx_buffered #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx         (tx),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge; the following posedge samples the strobe.
    task automatic strobe(input logic [7:0] b);
        tx.tx_ready = 1'b1;
        tx.sdata    = b;
        @(negedge clk);
        tx.tx_ready = 1'b0;
        tx.sdata    = 8'h00;
    endtask

    // Waits for a start bit, then checks all 10*CPB samples against the ideal waveform.
    task automatic recv_frame(input logic [7:0] exp_byte, input string tag, output int fall);
        int   waited = 0;
        int   errs = 0;
        int   pos;
        logic eb;
        logic [7:0] got = 8'h00;
        while (txd !== 1'b0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        fall = cyc;
        chk({tag, " start"}, 32'(txd), 32'd0);
        if (txd !== 1'b0) return;
        for (int j = 0; j < 10 * CPB; j++) begin
            pos = j / CPB;
            if (pos == 0)      eb = 1'b0;
            else if (pos == 9) eb = 1'b1;
            else               eb = exp_byte[pos-1];
            if (txd !== eb) errs++;
            if ((j % CPB) == CPB / 2 && pos >= 1 && pos <= 8) got[pos-1] = txd;
            if (j == 10 * CPB - 1) busy39 = busy;
            @(negedge clk);
        end
        chk({tag, " wave_errs"}, 32'(errs), 32'd0);
        chk({tag, " byte"}, 32'(got), 32'(exp_byte));
    endtask

    initial begin
        int t;
        int f0, f1, f2, f3, f4, f5;
        int errs;
        rstn        = 1'b0;
        tx.tx_ready = 1'b0;
        tx.sdata    = 8'h00;

        // 1: reset
        repeat (3) @(negedge clk);
        chk("rst txd", 32'(txd), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst count", 32'(fifo_count), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 2: single byte 0x55
        t = cyc + 1;
        fork
            strobe(8'h55);
            recv_frame(8'h55, "t2", f0);
        join
        chk("t2 latency", 32'(f0 - t), 32'd2);
        chk("t2 busy end-1", 32'(busy39), 32'd1);
        chk("t2 busy end", 32'(busy), 32'd0);
        chk("t2 busy delay", 32'(cyc - f0), 32'd40);
        repeat (5) @(negedge clk);

        // 3: burst of three
        t = cyc + 1;
        fork
            begin
                strobe(8'h41);
                strobe(8'h42);
                strobe(8'h43);
                chk("t3 count", 32'(fifo_count), 32'd1);
            end
            begin
                recv_frame(8'h41, "t3a", f0);
                recv_frame(8'h42, "t3b", f1);
                recv_frame(8'h43, "t3c", f2);
            end
        join
        chk("t3 first fall", 32'(f0 - t), 32'd2);
        chk("t3 gap ab", 32'(f1 - f0), 32'd40);
        chk("t3 gap bc", 32'(f2 - f1), 32'd40);
        chk("t3 busy after", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // 4: six strobes, sixth dropped
        fork
            begin
                for (int i = 0; i < 6; i++) strobe(8'h10 + 8'(i));
                @(negedge clk);
                @(negedge clk);
                chk("t4 overflow set", 32'(overflow), 32'd1);
                chk("t4 count full", 32'(fifo_count), 32'd4);
            end
            begin
                recv_frame(8'h10, "t4a", f0);
                recv_frame(8'h11, "t4b", f1);
                recv_frame(8'h12, "t4c", f2);
                recv_frame(8'h13, "t4d", f3);
                recv_frame(8'h14, "t4e", f4);
            end
        join
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (txd !== 1'b1) errs++;
            @(negedge clk);
        end
        chk("t4 no sixth frame", 32'(errs), 32'd0);
        chk("t4 overflow sticky", 32'(overflow), 32'd1);
        chk("t4 count end", 32'(fifo_count), 32'd0);

        // 5: push while full coinciding with the STOP-end pop
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("t5 overflow cleared", 32'(overflow), 32'd0);
        @(negedge clk);
        t = cyc + 1;
        fork
            begin
                for (int i = 0; i < 5; i++) strobe(8'h20 + 8'(i));
                while (cyc < t + 40) @(negedge clk);
                chk("t5 count before", 32'(fifo_count), 32'd4);
                strobe(8'h25);
                chk("t5 count pre-edge", 32'(fifo_count), 32'd4);
                @(negedge clk);
                chk("t5 count after", 32'(fifo_count), 32'd4);
                chk("t5 overflow", 32'(overflow), 32'd0);
            end
            begin
                recv_frame(8'h20, "t5a", f0);
                recv_frame(8'h21, "t5b", f1);
                recv_frame(8'h22, "t5c", f2);
                recv_frame(8'h23, "t5d", f3);
                recv_frame(8'h24, "t5e", f4);
                recv_frame(8'h25, "t5f", f5);
            end
        join
        chk("t5 overflow end", 32'(overflow), 32'd0);
        chk("t5 last gap", 32'(f5 - f4), 32'd40);
        repeat (5) @(negedge clk);

        // 6: reset during DATA bit 3 of 0xA5
        t = cyc + 1;
        strobe(8'hA5);
        strobe(8'h77);
        while (cyc < t + 18) @(negedge clk);
        chk("t6 bit3 value", 32'(txd), 32'd0);
        chk("t6 count queued", 32'(fifo_count), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6 rst txd", 32'(txd), 32'd1);
        chk("t6 rst count", 32'(fifo_count), 32'd0);
        chk("t6 rst busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        t = cyc + 1;
        fork
            strobe(8'h3C);
            recv_frame(8'h3C, "t6 clean", f0);
        join
        chk("t6 latency", 32'(f0 - t), 32'd2);
        chk("t6 busy end", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
